// File: rtl/rgb2axis_pkg.sv
// rgb2axis_pkg: capture FSM encoding, FIFO entry layout and tdata field offsets.
package rgb2axis_pkg;
  typedef enum logic [1:0] {IDLE, WAIT_SOF, ACTIVE, DROP} state_t;
  localparam int ENTRY_W = 26;
  localparam int TUSER_BIT = 25;
  localparam int TLAST_BIT = 24;
  localparam int R_OFS = 16;
  localparam int B_OFS = 8;
  localparam int G_OFS = 0;
endpackage

// File: rtl/rgb2axis_fifo.sv
// rgb2axis_fifo: single-clock FIFO with registered head output; rst_int is asynchronous active-low.
module rgb2axis_fifo
  import rgb2axis_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic               pixclk,
  input  logic               rst_int,
  input  logic               push,
  input  logic [ENTRY_W-1:0] din,
  input  logic               pop,
  output logic [ENTRY_W-1:0] dout,
  output logic               full,
  output logic               empty
);
  localparam int AW = $clog2(DEPTH);
  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0] cnt;
  logic do_push, do_pop;
  assign empty = cnt == '0;
  assign full = cnt == (AW+1)'(DEPTH);
  assign do_pop = pop && !empty;
  // a pop frees the slot a push into a full FIFO needs
  assign do_push = push && (!full || do_pop);
  always_ff @(posedge pixclk)
    if (do_push) mem[wr_ptr] <= din;
  // dout always tracks the entry at rd_ptr, so it is loaded from din or the next slot
  always_ff @(posedge pixclk or negedge rst_int)
    if (!rst_int) begin
      dout <= '0;
      cnt <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
      if (do_push && (empty || (do_pop && cnt == (AW+1)'(1)))) dout <= din;
      else if (do_pop && cnt > (AW+1)'(1)) dout <= mem[rd_ptr + 1'b1];
    end
endmodule

// File: rtl/rgb2axis.sv
// rgb2axis: parallel RGB video to AXI4-Stream video with frame sync, one-pixel hold and output FIFO.
// Define RGB2AXIS_DROP_CNT_EN to add the saturating drop_cnt output.
module rgb2axis
  import rgb2axis_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int TDATA_W = 24
) (
  input  logic               pixclk,
  input  logic               config_done,
  input  logic               rgb_fv,
  input  logic               rgb_lv,
  input  logic [7:0]         data_r,
  input  logic [7:0]         data_g,
  input  logic [7:0]         data_b,
  output logic [TDATA_W-1:0] m_axis_tdata,
  output logic               m_axis_tvalid,
  input  logic               m_axis_tready,
  output logic               m_axis_tuser,
  output logic               m_axis_tlast,
  output logic               ovf
`ifdef RGB2AXIS_DROP_CNT_EN
  ,
  output logic [15:0]        drop_cnt
`endif
);
  state_t state;
  logic fv_q, hold_vld, first, full, empty, pop, push, ovf_evt, sof, take, tlast;
  logic [23:0] hold, pix;
  logic [ENTRY_W-1:0] fifo_dout;
  always_comb begin
    pix = '0;
    pix[R_OFS+:8] = data_r;
    pix[B_OFS+:8] = data_b;
    pix[G_OFS+:8] = data_g;
  end
  assign pop = m_axis_tvalid && m_axis_tready;
  assign sof = state == WAIT_SOF && rgb_fv && !fv_q;
  // the held pixel always leaves on the cycle after capture: next pixel, line end or frame end
  assign push = state == ACTIVE && hold_vld;
  assign ovf_evt = push && full && !pop;
  assign tlast = !rgb_lv || !rgb_fv;
  assign take = rgb_fv && rgb_lv && (sof || (state == ACTIVE && !ovf_evt));
  rgb2axis_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .pixclk (pixclk),
    .rst_int(config_done),
    .push   (push),
    .din    ({first, tlast, hold}),
    .pop    (pop),
    .dout   (fifo_dout),
    .full   (full),
    .empty  (empty)
  );
  assign m_axis_tvalid = !empty;
  assign m_axis_tdata = fifo_dout[TDATA_W-1:0];
  assign m_axis_tuser = fifo_dout[TUSER_BIT];
  assign m_axis_tlast = fifo_dout[TLAST_BIT];
  always_ff @(posedge pixclk or negedge config_done)
    if (!config_done) begin
      state <= IDLE;
      fv_q <= 1'b0;
      hold_vld <= 1'b0;
      hold <= '0;
      first <= 1'b0;
      ovf <= 1'b0;
    end else begin
      fv_q <= rgb_fv;
      hold_vld <= take;
      if (take) hold <= pix;
      if (push && !ovf_evt) first <= 1'b0;
      if (sof) first <= 1'b1;
      if (sof) ovf <= 1'b0;
      else if (ovf_evt) ovf <= 1'b1;
      case (state)
        IDLE:     state <= rgb_fv ? IDLE : WAIT_SOF;
        WAIT_SOF: state <= sof ? ACTIVE : WAIT_SOF;
        ACTIVE:   state <= !rgb_fv ? WAIT_SOF : ovf_evt ? DROP : ACTIVE;
        DROP:     state <= rgb_fv ? DROP : WAIT_SOF;
        default:  state <= IDLE;
      endcase
    end
`ifdef RGB2AXIS_DROP_CNT_EN
  logic [16:0] drop_sum;
  assign drop_sum = 17'(drop_cnt) + 17'(ovf_evt) + 17'(rgb_fv && rgb_lv && (ovf_evt || state == DROP));
  always_ff @(posedge pixclk or negedge config_done)
    if (!config_done) drop_cnt <= '0;
    else drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
`endif
endmodule

// File: tb/tb_rgb2axis.sv
// tb_rgb2axis: randomized and directed bench for rgb2axis against a frame-level beat queue model.
module tb_rgb2axis;
  logic pixclk = 1'b0;
  logic config_done = 1'b1;
  logic rgb_fv = 1'b0;
  logic rgb_lv = 1'b0;
  logic [7:0] data_r = '0, data_g = '0, data_b = '0;
  logic m_axis_tready = 1'b1;
  logic [23:0] m_axis_tdata;
  logic m_axis_tvalid, m_axis_tuser, m_axis_tlast, ovf;
`ifdef RGB2AXIS_DROP_CNT_EN
  logic [15:0] drop_cnt;
`endif
  int n_chk = 0;
  int n_err = 0;
  int rmode = 0;
  int pix_n = 0;
  logic [25:0] exp_q[$];

  always #5 pixclk = ~pixclk;

  rgb2axis #(.FIFO_DEPTH(4)) dut (
    .pixclk       (pixclk),
    .config_done  (config_done),
    .rgb_fv       (rgb_fv),
    .rgb_lv       (rgb_lv),
    .data_r       (data_r),
    .data_g       (data_g),
    .data_b       (data_b),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tuser (m_axis_tuser),
    .m_axis_tlast (m_axis_tlast),
    .ovf          (ovf)
`ifdef RGB2AXIS_DROP_CNT_EN
    ,
    .drop_cnt     (drop_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // expected stream beat {tuser, tlast, r, b, g} from an input pixel {r, g, b}
  function automatic logic [25:0] beat(input logic u, input logic l, input logic [23:0] px);
    return {u, l, px[23:16], px[7:0], px[15:8]};
  endfunction

  function automatic logic [23:0] next_px();
    int k = pix_n;
    pix_n++;
    return {8'(3*k+1), 8'(3*k+2), 8'(3*k+3)};
  endfunction

  task automatic cyc(input logic fv, input logic lv, input logic [23:0] px);
    @(posedge pixclk);
    #1;
    rgb_fv = fv;
    rgb_lv = lv;
    {data_r, data_g, data_b} = px;
    if (rmode == 0) m_axis_tready = 1'b1;
    else if (rmode == 1) m_axis_tready = ~m_axis_tready;
    else if (rmode == 2) m_axis_tready = $urandom_range(0, 3) != 0;
    else m_axis_tready = 1'b0;
  endtask

  task automatic drain(input logic fv);
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) cyc(fv, 1'b0, '0);
    chk("drain", exp_q.size(), 0);
  endtask

  task automatic frame(input int nl, input int ll, input bit rnd);
    logic [23:0] px;
    int len;
    cyc(1'b1, 1'b0, '0);
    cyc(1'b1, 1'b0, '0);
    for (int l = 0; l < nl; l++) begin
      len = rnd ? int'($urandom_range(1, 4)) : ll;
      for (int p = 0; p < len; p++) begin
        px = rnd ? 24'($urandom) : next_px();
        exp_q.push_back(beat(l == 0 && p == 0, p == len - 1, px));
        cyc(1'b1, 1'b1, px);
      end
      cyc(1'b1, 1'b0, '0);
      drain(1'b1);
    end
    cyc(1'b0, 1'b0, '0);
    cyc(1'b0, 1'b0, '0);
  endtask

  logic pv = 1'b0, pr = 1'b0;
  logic [25:0] pb = '0;
  always @(negedge pixclk) begin
    if (config_done) begin
      if (pv && !pr) begin
        chk("tvalid_hold", m_axis_tvalid, 1);
        chk("beat_stable", {m_axis_tuser, m_axis_tlast, m_axis_tdata}, pb);
      end
      if (m_axis_tvalid && m_axis_tready) begin
        chk("beat_avail", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) chk("beat", {m_axis_tuser, m_axis_tlast, m_axis_tdata}, exp_q.pop_front());
      end
      pv = m_axis_tvalid;
      pr = m_axis_tready;
      pb = {m_axis_tuser, m_axis_tlast, m_axis_tdata};
    end else pv = 1'b0;
  end

  initial begin
    logic [23:0] px;
    #1 config_done = 1'b0;
    #2;
    chk("rst_tvalid", m_axis_tvalid, 0);
    chk("rst_tdata", m_axis_tdata, 0);
    chk("rst_tuser", m_axis_tuser, 0);
    chk("rst_tlast", m_axis_tlast, 0);
    chk("rst_ovf", ovf, 0);
`ifdef RGB2AXIS_DROP_CNT_EN
    chk("rst_drop_cnt", drop_cnt, 0);
`endif
    repeat (3) @(posedge pixclk);
    #1 config_done = 1'b1;
    cyc(1'b0, 1'b0, '0);
    cyc(1'b0, 1'b0, '0);
    // 4x2 frame, full-rate and half-rate sink
    rmode = 0;
    pix_n = 0;
    frame(2, 4, 0);
    chk("ovf_full_rate", ovf, 0);
    rmode = 1;
    pix_n = 0;
    frame(2, 4, 0);
    chk("ovf_toggle", ovf, 0);
    // 1x1 frame with two-cycle latency
    rmode = 0;
    cyc(1'b1, 1'b0, '0);
    cyc(1'b1, 1'b0, '0);
    px = next_px();
    exp_q.push_back(beat(1'b1, 1'b1, px));
    cyc(1'b1, 1'b1, px);
    cyc(1'b1, 1'b0, '0);
    @(negedge pixclk);
    chk("lat_n1_tvalid", m_axis_tvalid, 0);
    cyc(1'b1, 1'b0, '0);
    @(negedge pixclk);
    chk("lat_n2_tvalid", m_axis_tvalid, 1);
    chk("lat_n2_tuser", m_axis_tuser, 1);
    chk("lat_n2_tlast", m_axis_tlast, 1);
    cyc(1'b0, 1'b0, '0);
    drain(1'b0);
    // overflow: 16-pixel line into a 4-entry FIFO with a stalled sink
    rmode = 3;
    cyc(1'b1, 1'b0, '0);
    cyc(1'b1, 1'b0, '0);
    for (int i = 0; i < 16; i++) begin
      px = next_px();
      if (i < 4) exp_q.push_back(beat(i == 0, 1'b0, px));
      cyc(1'b1, 1'b1, px);
    end
    cyc(1'b1, 1'b0, '0);
    cyc(1'b1, 1'b0, '0);
    chk("ovf_set", ovf, 1);
    chk("ovf_tvalid", m_axis_tvalid, 1);
`ifdef RGB2AXIS_DROP_CNT_EN
    chk("drop_cnt_line", drop_cnt, 12);
`endif
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, next_px());
    cyc(1'b1, 1'b0, '0);
    cyc(1'b0, 1'b0, '0);
`ifdef RGB2AXIS_DROP_CNT_EN
    chk("drop_cnt_drop", drop_cnt, 15);
`endif
    rmode = 0;
    drain(1'b0);
    chk("ovf_sticky", ovf, 1);
    frame(1, 4, 0);
    chk("ovf_cleared", ovf, 0);
    // reset released while a frame is already running
    @(posedge pixclk);
    #1;
    rgb_fv = 1'b1;
    config_done = 1'b0;
    cyc(1'b1, 1'b0, '0);
    cyc(1'b1, 1'b0, '0);
    config_done = 1'b1;
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 24'($urandom));
    cyc(1'b1, 1'b0, '0);
    cyc(1'b1, 1'b0, '0);
    cyc(1'b1, 1'b0, '0);
    chk("midframe_release_quiet", m_axis_tvalid, 0);
    cyc(1'b0, 1'b0, '0);
    frame(2, 3, 0);
    // reset pulse in the middle of a line
    rmode = 3;
    cyc(1'b1, 1'b0, '0);
    cyc(1'b1, 1'b0, '0);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 24'($urandom));
    @(negedge pixclk);
    chk("pre_rst_tvalid", m_axis_tvalid, 1);
    @(posedge pixclk);
    #2 config_done = 1'b0;
    #1;
    chk("pulse_tvalid", m_axis_tvalid, 0);
    chk("pulse_tuser", m_axis_tuser, 0);
    chk("pulse_tdata", m_axis_tdata, 0);
    cyc(1'b1, 1'b1, 24'($urandom));
    config_done = 1'b1;
    cyc(1'b1, 1'b1, 24'($urandom));
    cyc(1'b1, 1'b0, '0);
    cyc(1'b0, 1'b0, '0);
    rmode = 0;
    cyc(1'b0, 1'b0, '0);
    chk("pulse_empty", m_axis_tvalid, 0);
    frame(2, 3, 0);
    // random frames with a random sink
    rmode = 2;
    for (int f = 0; f < 8; f++) frame(int'($urandom_range(1, 3)), 0, 1);
    chk("ovf_random", ovf, 0);
    rmode = 0;
    drain(1'b0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/rgb2axis.md
RGB2AXIS -- requirements
Module: rgb2axis

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16, output FIFO entries (power of two, 4..1024).
REQ-002 SHALL have parameter TDATA_W, default 24, AXI4-Stream video data width (fixed at 24).
REQ-003 pixclk  in  1  sole clock; all logic rising-edge.
REQ-004 config_done  in  1  reset, asynchronous assert, active-low; held low until sensor configuration completes.
REQ-005 rgb_fv  in  1  frame-valid from the demosaic stage.
REQ-006 rgb_lv  in  1  line-valid; pixel present on each cycle it is high.
REQ-007 data_r, data_g, data_b  in  8 each  pixel components, qualified by rgb_lv.
REQ-008 m_axis_tdata  out  24  packed pixel {data_r, data_b, data_g}.
REQ-009 m_axis_tvalid / m_axis_tready  out / in  1  AXI4-Stream handshake.
REQ-010 m_axis_tuser  out  1  start-of-frame, first pixel of frame only.
REQ-011 m_axis_tlast  out  1  end-of-line, last pixel of each line.
REQ-012 ovf  out  1  sticky overflow flag for the current frame.

Function
REQ-013 FSM states IDLE, WAIT_SOF, ACTIVE, DROP; reset enters IDLE.
REQ-014 IDLE -> WAIT_SOF once rgb_fv sampled low, so capture never starts mid-frame.
REQ-015 WAIT_SOF -> ACTIVE on rgb_fv rising edge (registered rgb_fv low, current high); ovf cleared on this edge.
REQ-016 ACTIVE: each rgb_lv-high pixel is first captured in a one-entry hold register; the held pixel is pushed to the FIFO on the next valid pixel (tlast=0) or on the first cycle rgb_lv is low (tlast=1).
REQ-017 First pushed pixel after SOF carries tuser=1; all others tuser=0.
REQ-018 rgb_fv falling while ACTIVE: any held pixel pushed with tlast=1 that cycle, then -> WAIT_SOF.
REQ-019 Push when FIFO full: pixel discarded, ovf=1, -> DROP; DROP discards all input until rgb_fv falls, then -> WAIT_SOF.
REQ-020 Single-pixel line: pushed with tlast=1 (and tuser=1 if first of frame).
REQ-021 FIFO entry 26 bits {tuser, tlast, tdata}; pop when m_axis_tvalid and m_axis_tready both high.
REQ-022 m_axis_tvalid high whenever FIFO non-empty; tdata/tuser/tlast stable while tvalid high and tready low.
REQ-023 Simultaneous push and pop on a full FIFO is accepted without overflow.
REQ-024 Latency, empty FIFO, tready=1: pixel at input cycle N appears on m_axis_tdata at cycle N+2 at the earliest (hold + FIFO output register), and its push decision is made at cycle N+1.
REQ-025 Sustained throughput one pixel per cycle when tready=1.

Reset
REQ-026 config_done low: m_axis_tvalid=0, tdata=0, tuser=0, tlast=0, ovf=0, FIFO empty, hold register empty, FSM IDLE.
REQ-027 Reset mid-frame aborts the frame; after release the block resynchronises via IDLE and emits nothing before the next full frame.

Configuration
REQ-028 Macro RGB2AXIS_DROP_CNT_EN: when defined, adds output drop_cnt (16 bits) counting discarded pixels, saturating at 0xFFFF, cleared on reset only.
REQ-029 Without RGB2AXIS_DROP_CNT_EN, port drop_cnt and its counter are absent; all other behaviour identical.

Structure
REQ-030 Package rgb2axis_pkg holds FSM state encoding, FIFO entry width (26) and tdata field offsets.
REQ-031 FIFO is sub-module rgb2axis_fifo (synchronous, single clock, registered output, full/empty flags); FSM, hold register and packing live in rgb2axis.

Verification
REQ-032 4x2 frame, tready=1, pixels 0x010203..: 8 beats, tuser only on beat 0, tlast on beats 3 and 7, tdata beat 0 = 0x010302.
REQ-033 Same frame, tready toggling 1/0 every cycle: identical beat sequence, no loss, ovf=0.
REQ-034 FIFO_DEPTH=4, 16-pixel line, tready=0: exactly 4 beats stored, ovf=1, DROP until rgb_fv low; next frame clears ovf and streams normally; drop_cnt=12 when macro defined.
REQ-035 Release reset with rgb_fv already high: no output until rgb_fv falls and rises again.
REQ-036 config_done pulsed low mid-line: tvalid=0 within same cycle, FIFO empty, next full frame delivered correctly with tuser on first beat.
REQ-037 1x1 frame: single beat with tuser=1 and tlast=1.
